// File: rtl/conv_window_gen_if.sv
// conv_window_gen_if: pixel-in / window-out bundle for the 3x3 window generator.
//   sof        : start-of-frame, qualified by pix_valid
//   pix_valid  : pixel strobe (no backpressure)
//   pix_in     : one pixel, channel 0 in the MSB slice
//   win_valid  : one-cycle pulse per emitted window
//   win_out    : packed 3x3xIN_CH window, channel 0 / tap 0 in the MSBs
//   row_out    : row of the window's bottom-right tap
//   col_out    : column of the window's bottom-right tap
//   frame_done : pulses with the last window of a frame
// master drives pixels (upstream), slave produces windows (the generator).
interface conv_window_gen_if #(
    parameter int DATA_W = 8,
    parameter int IN_CH  = 3,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32
);
    logic                         sof;
    logic                         pix_valid;
    logic [IN_CH*DATA_W-1:0]      pix_in;
    logic                         win_valid;
    logic [IN_CH*DATA_W*9-1:0]    win_out;
    logic [$clog2(IMG_H)-1:0]     row_out;
    logic [$clog2(IMG_W)-1:0]     col_out;
    logic                         frame_done;
    modport master (
        output sof, pix_valid, pix_in,
        input  win_valid, win_out, row_out, col_out, frame_done
    );
    modport slave (
        input  sof, pix_valid, pix_in,
        output win_valid, win_out, row_out, col_out, frame_done
    );
endinterface

// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming 3x3 "valid" convolution window generator, stride 1.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : conv_window_gen_if slave; pixels in raster order, packed windows out
// Two line buffers per pixel (all channels side by side) hold rows r-1 and r-2;
// a 3x3 shift register per channel forms the window. Outputs are registered,
// one cycle after the accepting edge.
module conv_window_gen #(
    parameter int DATA_W = 8,
    parameter int IN_CH  = 3,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32
) (
    input logic              clk,
    input logic              rst,
    conv_window_gen_if.slave bus
);
    localparam int PW = IN_CH * DATA_W;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [PW-1:0]     lb0_q [IMG_W];
    logic [PW-1:0]     lb1_q [IMG_W];
    logic [DATA_W-1:0] sh_q [IN_CH][3][3];
    logic [DATA_W-1:0] sh_d [IN_CH][3][3];
    logic [CW-1:0]     col_q, col_d, cur_col;
    logic [RW-1:0]     row_q, row_d, cur_row;
    logic [PW-1:0]     top, mid;
    logic              sof_v, last_col, last_row;
    logic              win_valid_q, win_valid_d;
    logic              frame_done_q, frame_done_d;
    logic [RW-1:0]     row_out_q;
    logic [CW-1:0]     col_out_q;

    // sof restarts the frame at this very pixel, so it overrides the counters
    // combinationally; the column counter doubles as the line-buffer write pointer.
    always_comb begin
        sof_v        = bus.sof & bus.pix_valid;
        cur_col      = sof_v ? '0 : col_q;
        cur_row      = sof_v ? '0 : row_q;
        top          = lb0_q[cur_col];
        mid          = lb1_q[cur_col];
        last_col     = cur_col == CW'(IMG_W - 1);
        last_row     = cur_row == RW'(IMG_H - 1);
        col_d        = last_col ? '0 : cur_col + CW'(1);
        row_d        = last_col ? (last_row ? '0 : cur_row + RW'(1)) : cur_row;
        win_valid_d  = bus.pix_valid && cur_row >= RW'(2) && cur_col >= CW'(2);
        frame_done_d = win_valid_d && last_row && last_col;
    end

    // Window shifts left; the new right column is {row r-2, row r-1, row r}
    // taken from the line buffers before this pixel's write lands.
    always_comb begin
        for (int k = 0; k < IN_CH; k++) begin
            for (int i = 0; i < 3; i++) begin
                sh_d[k][i][0] = sh_q[k][i][1];
                sh_d[k][i][1] = sh_q[k][i][2];
            end
            sh_d[k][0][2] = top[(IN_CH-1-k)*DATA_W +: DATA_W];
            sh_d[k][1][2] = mid[(IN_CH-1-k)*DATA_W +: DATA_W];
            sh_d[k][2][2] = bus.pix_in[(IN_CH-1-k)*DATA_W +: DATA_W];
        end
    end

    // Line-buffer RAM: no reset, rows 0/1 of every frame rewrite it before use.
    always_ff @(posedge clk) begin
        if (bus.pix_valid) begin
            lb0_q[cur_col] <= mid;
            lb1_q[cur_col] <= bus.pix_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            sh_q         <= '{default: '0};
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            row_out_q    <= '0;
            col_out_q    <= '0;
        end else begin
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            if (bus.pix_valid) begin
                col_q <= col_d;
                row_q <= row_d;
                sh_q  <= sh_d;
            end
            if (win_valid_d) begin
                row_out_q <= cur_row;
                col_out_q <= cur_col;
            end
        end
    end

    // The shift register is the output register: after an emitting edge it
    // holds exactly that window, and it only moves on accepted pixels, so
    // win_out holds through idle cycles.
    for (genvar k = 0; k < IN_CH; k++) begin : g_ch
        for (genvar t = 0; t < 9; t++) begin : g_tap
            assign bus.win_out[((IN_CH-1-k)*9 + 8 - t)*DATA_W +: DATA_W] = sh_q[k][t/3][t%3];
        end
    end

    assign bus.win_valid  = win_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.row_out    = row_out_q;
    assign bus.col_out    = col_out_q;
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: self-checking bench; a 1-channel and a 3-channel 5x4 instance
// share one pixel stream and are compared against an image-array reference model.
module tb_conv_window_gen;
    localparam int DW = 8;
    localparam int W  = 5;
    localparam int H  = 4;

    typedef struct {
        int          r;
        int          c;
        logic [71:0] w;
        bit          fd;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    conv_window_gen_if #(.DATA_W(DW), .IN_CH(1), .IMG_W(W), .IMG_H(H)) a_if();
    conv_window_gen_if #(.DATA_W(DW), .IN_CH(3), .IMG_W(W), .IMG_H(H)) b_if();

    conv_window_gen #(.DATA_W(DW), .IN_CH(1), .IMG_W(W), .IMG_H(H)) dut1 (
        .clk(clk), .rst(rst), .bus(a_if)
    );
    conv_window_gen #(.DATA_W(DW), .IN_CH(3), .IMG_W(W), .IMG_H(H)) dut3 (
        .clk(clk), .rst(rst), .bus(b_if)
    );

    // reference model: the current frame as an image, plus the next raster position
    logic [DW-1:0] img [H][W][3];
    int            mr = 0;
    int            mc = 0;
    logic [71:0]   exp1 = '0;
    logic [215:0]  exp3 = '0;
    bit            last_emit = 0;
    int            n_win = 0;
    int            n_fd = 0;
    int            cap_r[$];
    int            cap_c[$];
    logic [71:0]   cap_w[$];
    bit            cap_f[$];
    logic [215:0]  cap_w3[$];
    vec_t          tbl [6];

    task automatic chk(string name, logic [215:0] act, logic [215:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        a_if.sof = 0; a_if.pix_valid = 0; a_if.pix_in = '0;
        b_if.sof = 0; b_if.pix_valid = 0; b_if.pix_in = '0;
    endtask

    task automatic clear_caps();
        cap_r.delete(); cap_c.delete(); cap_w.delete(); cap_f.delete(); cap_w3.delete();
        n_win = 0;
        n_fd = 0;
    endtask

    task automatic model_reset();
        mr = 0;
        mc = 0;
        exp1 = '0;
        exp3 = '0;
        last_emit = 0;
    endtask

    // one clock: drive a pixel (or idle), predict, clock, check 1 ns after the edge
    task automatic step(bit s, bit v, logic [DW-1:0] p0, logic [DW-1:0] p1, logic [DW-1:0] p2);
        int  r;
        int  c;
        bit  ev;
        bit  efd;
        ev = 0;
        efd = 0;
        a_if.sof = s; a_if.pix_valid = v; a_if.pix_in = p0;
        b_if.sof = s; b_if.pix_valid = v; b_if.pix_in = {p0, p1, p2};
        if (v) begin
            if (s) begin
                mr = 0;
                mc = 0;
            end
            r = mr;
            c = mc;
            img[r][c][0] = p0;
            img[r][c][1] = p1;
            img[r][c][2] = p2;
            ev = r >= 2 && c >= 2;
            efd = ev && r == H - 1 && c == W - 1;
            if (ev) begin
                for (int t = 0; t < 9; t++) begin
                    exp1[(8 - t)*8 +: 8] = img[r - 2 + t/3][c - 2 + t%3][0];
                    for (int k = 0; k < 3; k++)
                        exp3[((2 - k)*9 + 8 - t)*8 +: 8] = img[r - 2 + t/3][c - 2 + t%3][k];
                end
            end
            last_emit = ev;
            mc = (c + 1) % W;
            if (mc == 0) mr = (r + 1) % H;
        end
        @(posedge clk);
        #1;
        chk("win_valid1", a_if.win_valid, ev);
        chk("win_valid3", b_if.win_valid, ev);
        chk("frame_done1", a_if.frame_done, efd);
        chk("frame_done3", b_if.frame_done, efd);
        if (ev) begin
            chk("win_out1", a_if.win_out, exp1);
            chk("win_out3", b_if.win_out, exp3);
            chk("row_out", a_if.row_out, r);
            chk("col_out", a_if.col_out, c);
            chk("row_out3", b_if.row_out, r);
            chk("col_out3", b_if.col_out, c);
        end else if (!v && last_emit) begin
            chk("hold1", a_if.win_out, exp1);
            chk("hold3", b_if.win_out, exp3);
        end
        if (a_if.win_valid === 1'b1) begin
            n_win++;
            cap_r.push_back(int'(a_if.row_out));
            cap_c.push_back(int'(a_if.col_out));
            cap_w.push_back(a_if.win_out);
            cap_f.push_back(a_if.frame_done);
            cap_w3.push_back(b_if.win_out);
        end
        if (a_if.frame_done === 1'b1) n_fd++;
        idle_inputs();
    endtask

    // pixels idx0..idx1-1 of a frame; value 10r+c (+64 per channel) or random
    task automatic frame(bit gaps, bit rnd, bit s0, int idx0, int idx1);
        logic [DW-1:0] p;
        int r;
        int c;
        for (int i = idx0; i < idx1; i++) begin
            r = i / W;
            c = i % W;
            p = rnd ? DW'($urandom) : DW'(10*r + c);
            if (gaps) repeat ($urandom_range(0, 2)) step(0, 0, 0, 0, 0);
            step(s0 && i == idx0, 1, p, rnd ? DW'($urandom) : DW'(p + 64),
                 rnd ? DW'($urandom) : DW'(p + 128));
        end
    endtask

    task automatic check_table(string tag);
        chk({tag, "_count"}, cap_r.size(), 6);
        for (int i = 0; i < 6 && i < cap_r.size(); i++) begin
            chk({tag, "_row"}, cap_r[i], tbl[i].r);
            chk({tag, "_col"}, cap_c[i], tbl[i].c);
            chk({tag, "_win"}, cap_w[i], tbl[i].w);
            chk({tag, "_fd"}, cap_f[i], tbl[i].fd);
        end
    endtask

    initial begin
        logic [215:0] w3;
        tbl[0] = '{2, 2, {8'd0,  8'd1,  8'd2,  8'd10, 8'd11, 8'd12, 8'd20, 8'd21, 8'd22}, 1'b0};
        tbl[1] = '{2, 3, {8'd1,  8'd2,  8'd3,  8'd11, 8'd12, 8'd13, 8'd21, 8'd22, 8'd23}, 1'b0};
        tbl[2] = '{2, 4, {8'd2,  8'd3,  8'd4,  8'd12, 8'd13, 8'd14, 8'd22, 8'd23, 8'd24}, 1'b0};
        tbl[3] = '{3, 2, {8'd10, 8'd11, 8'd12, 8'd20, 8'd21, 8'd22, 8'd30, 8'd31, 8'd32}, 1'b0};
        tbl[4] = '{3, 3, {8'd11, 8'd12, 8'd13, 8'd21, 8'd22, 8'd23, 8'd31, 8'd32, 8'd33}, 1'b0};
        tbl[5] = '{3, 4, {8'd12, 8'd13, 8'd14, 8'd22, 8'd23, 8'd24, 8'd32, 8'd33, 8'd34}, 1'b1};
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_win_valid1", a_if.win_valid, 0);
        chk("rst_win_out1", a_if.win_out, 0);
        chk("rst_row1", a_if.row_out, 0);
        chk("rst_col1", a_if.col_out, 0);
        chk("rst_fd1", a_if.frame_done, 0);
        chk("rst_win_valid3", b_if.win_valid, 0);
        chk("rst_win_out3", b_if.win_out, 0);
        chk("rst_fd3", b_if.frame_done, 0);
        rst = 0;
        // contiguous 10r+c frame, started with sof
        clear_caps();
        frame(0, 0, 1, 0, W*H);
        check_table("contig");
        chk("contig_frames", n_fd, 1);
        chk("ch_count", cap_w3.size(), 6);
        if (cap_w3.size() > 0) begin
            w3 = cap_w3[0];
            chk("ch0_tap0", w3[215:208], 0);
            chk("ch2_tap8", w3[7:0], 150);
        end
        // same frame with idle gaps
        clear_caps();
        frame(1, 0, 0, 0, W*H);
        check_table("gaps");
        // two back-to-back random frames, no sof
        clear_caps();
        frame(0, 1, 0, 0, W*H);
        frame(0, 1, 0, 0, W*H);
        chk("b2b_windows", n_win, 12);
        chk("b2b_frames", n_fd, 2);
        // sof at (2,3) truncates the frame
        frame(0, 0, 0, 0, 13);
        clear_caps();
        step(1, 1, 8'd99, 8'd98, 8'd97);
        chk("sof_no_window", n_win, 0);
        frame(0, 1, 0, 1, W*H);
        chk("sof_windows", n_win, 6);
        chk("sof_frames", n_fd, 1);
        if (cap_r.size() > 0) begin
            chk("sof_first_row", cap_r[0], 2);
            chk("sof_first_col", cap_c[0], 2);
        end
        // reset while a window is being presented
        frame(0, 0, 0, 0, 13);
        chk("pre_rst_valid", a_if.win_valid, 1);
        rst = 1;
        #1;
        chk("arst_win_valid", a_if.win_valid, 0);
        chk("arst_win_out", a_if.win_out, 0);
        chk("arst_fd", a_if.frame_done, 0);
        chk("arst_win_out3", b_if.win_out, 0);
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        clear_caps();
        frame(0, 0, 0, 0, W*H);
        check_table("post_rst");
        // random traffic: random values, gaps and occasional sof
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 24) == 0, $urandom_range(0, 1) == 1,
                 DW'($urandom), DW'($urandom), DW'($urandom));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Streaming 3x3 window generator that sits directly upstream of the per-output-channel convolution accumulator.
- Accepts one multi-channel pixel per valid cycle in raster order and buffers two previous image rows per channel.
- Emits one packed 3x3xIN_CH window per valid output position. Convolution is "valid" style: no padding, stride 1.
- The output bus packing is the accumulator's window input format, so the two blocks connect without glue.

Parameters:
- DATA_W, 8: bits per pixel sample (signed, passed through unmodified).
- IN_CH, 3: input channels per pixel.
- IMG_W, 32: image width in pixels; legal range 3..1024.
- IMG_H, 32: image height in rows; legal range 3..1024.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- sof  in  1  start-of-frame; qualified by pix_valid; marks the current pixel as (row 0, col 0).
- pix_valid  in  1  pixel-in strobe; no backpressure, and the block accepts every strobe.
- pix_in  in  IN_CH*DATA_W  one pixel; channel 0 in the MSB slice.
- win_valid  out  1  registered; one-cycle pulse per emitted window.
- win_out  out  IN_CH*DATA_W*9  registered packed window; channel 0 in the MSB 9*DATA_W slice; within a channel, tap 0 (top-left) in the MSB DATA_W, then row-major through tap 8 (bottom-right) in the LSBs.
- row_out  out  clog2(IMG_H)  row index of the window's bottom-right tap; valid with win_valid.
- col_out  out  clog2(IMG_W)  column index of the window's bottom-right tap; valid with win_valid.
- frame_done  out  1  registered one-cycle pulse with the last window of a frame.

Behaviour:
- Reset (async, rst=1): the following clear to 0:
  - outputs win_valid, win_out, row_out, col_out, frame_done;
  - column and row counters;
  - the 3x3xIN_CH shift registers;
  - the line-buffer write pointer.
  Line-buffer RAM contents are don't-care.
- Storage: two line buffers per channel, IMG_W entries each.
  - LB1 holds row r-1 and LB0 holds row r-2.
  - On each accepted pixel at column c:
    - LB0[c] <= LB1[c];
    - LB1[c] <= pix_in;
    - the window shift registers shift left by one column, with the new right column = {LB0[c], LB1[c], pix_in} (top, mid, bottom), using pre-write values.
- Counters:
  - col increments per accepted pixel and wraps IMG_W-1 -> 0.
  - On that wrap, row increments.
  - When row = IMG_H-1 and col = IMG_W-1, both counters return to 0 (automatic next frame).
- Window emission: a pixel accepted at (r, c) with r >= 2 and c >= 2 causes the following on the next clock edge:
  - win_valid = 1;
  - win_out = rows r-2..r, cols c-2..c;
  - row_out = r, col_out = c.
  - Latency is exactly 1 cycle from the accepting edge.
- Columns 0 and 1 of every row produce no window. The shift registers still load, so no stale column from the previous row appears in the window.
- Windows per frame = (IMG_H-2)*(IMG_W-2).
- frame_done is asserted in the same cycle as the win_valid for (IMG_H-1, IMG_W-1).
- Cycles with pix_valid=0: no state change; win_valid and frame_done are 0. win_out holds its last value.
- sof with pix_valid=1: the pixel is treated as (0, 0) regardless of the counters, and the counters restart.
  - A truncated previous frame emits nothing further and frame_done is not pulsed for it.
  - The line buffers are not cleared. Rows 0/1 never emit, so the stale data is harmless.
- sof with pix_valid=0: ignored.
- Reset asserted mid-frame: outputs drop to 0 asynchronously. The first pixel after release is (0, 0), whether or not sof is asserted.
- Throughput: one pixel per cycle sustained, with no bubbles required.

Test Plan:
- Config IMG_W=5, IMG_H=4, IN_CH=1, DATA_W=8; stream pixel value = 10*r + c contiguously.
  - Required: exactly 6 win_valid pulses.
  - First window at (2,2): taps 0..8 = 00,01,02,10,11,12,20,21,22.
  - Last window at (3,4): taps 12,13,14,22,23,24,32,33,34, with frame_done=1 only on that cycle.
- IN_CH=3: channel k pixel = 10*r + c + 64*k.
  - Required: the MSB slice of win_out carries channel 0 taps, e.g. tap 0 = 8'd0 at (2,2), and the LSB slice carries channel 2, tap 8 = 8'd150.
- Random gaps on pix_valid (about 50% duty) over the first test's frame.
  - Required: identical window sequence.
  - win_valid exactly 1 cycle after each emitting pixel is accepted.
  - No pulses during idle cycles.
- Two back-to-back frames without sof.
  - Required: 12 windows total, 2 frame_done pulses, and the second frame's (2,2) window built only from second-frame data.
- sof asserted with pix_valid at pixel (2,3) of frame 1.
  - Required: no window for (2,3).
  - Counters restart, and the next emitted window is (2,2) of the new frame.
- Assert rst for 1 cycle mid-frame with win_valid=1.
  - Required: win_valid, win_out and frame_done read 0 immediately, before the next clock edge.
  - The following frame produces the same 6 windows as the first test.
